fs32_serial: RTL
================

// Module: fs32_serial
// PURPOSE
//  Digit-serial 32-bit subtractor, d = a - b - bi. The subtract counterpart of the fa32 adder
//  cell in the GPU/DSP ALU netlists, for paths that can trade latency for area: the
//  blitter address-compare and the divide-step helpers. Processes one DW-bit digit per clock,
//  LSB digit first, and produces borrow flags bo32/bo31/bo24, which mirror fa32's
//  co32/co31/co24 carry taps.
// PARAMETERS
//  DW      8   digit width in bits per clock; legal values 1,2,4,8 (must divide 24 and 32)
//  NSTEP   32/DW  derived localparam, not overridable; number of RUN cycles
// PORTS
//  sys_clk  in   1   system clock, all state on rising edge
//  reset    in   1   synchronous, active-high reset
//  start    in   1   request; sampled only in IDLE
//  a        in   32  minuend, captured on accepted start
//  b        in   32  subtrahend, captured on accepted start
//  bi       in   1   borrow-in to bit 0, captured on accepted start
//  busy     out  1   high while RUN
//  done     out  1   one-cycle pulse, result valid
//  d        out  32  difference, held until next accepted start
//  bo32     out  1   borrow out of bit 31 (unsigned a < b+bi)
//  bo31     out  1   borrow out of bit 30 into bit 31
//  bo24     out  1   borrow out of bit 23 into bit 24
//  ovf      out  1   signed overflow (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE, step=0, busy=0, done=0, d=0, bo32=bo31=bo24=0, ovf=0, internal borrow=0.
//  - States: IDLE -> RUN on start=1; RUN -> IDLE when step==NSTEP-1 (after that digit is stored).
//  - Accepted start (IDLE & start): latch a,b into shift regs, borrow<=bi, step<=0, busy<=1.
//    Outputs d/bo* are NOT cleared on start; they keep the old result until overwritten.
//  - RUN cycle k (k=0..NSTEP-1): {bn, dig} = a[k*DW+:DW] - b[k*DW+:DW] - borrow,
//    computed as DW+1-bit unsigned; store dig into d[k*DW+:DW]; borrow <= bn.
//    Per-bit borrow inside the digit is exposed so that bo31 and bo24 are taken at exact bit positions:
//    bo24 <= borrow out of bit 23 during the step containing bit 23;
//    bo31 <= borrow out of bit 30 during the final step; bo32 <= bn of final step.
//  - Latency: start sampled at edge N -> done=1 for the cycle after edge N+NSTEP (DW=8: 4 RUN
//    cycles, done visible 4 clocks after start). busy falls in the same cycle done rises.
//  - done is high for exactly 1 cycle; start in the done cycle is accepted (state is IDLE).
//  - start while busy: ignored, no effect on the operation in flight, no queuing.
//  - Widths: all arithmetic modulo 2^32; a=b, bi=0 -> d=0, all borrows 0.
//  - reset mid-RUN: abort immediately, all outputs to reset values, no done pulse.
//  - reset and start in the same cycle: reset wins; start is dropped.
// CONFIGURATION
//  FS32_OVF_EN defined: ovf <= bo31 ^ bo32, registered with the final step and held with d.
//  FS32_OVF_EN undefined: ovf tied 1'b0 and the XOR is not built; all other behaviour is identical.
// TESTING  (DW=8 unless noted)
//  1 a=5,b=3,bi=0,start -> 4 clk later done=1, d=0x00000002, bo32=bo31=bo24=0
//  2 a=0,b=1,bi=0 -> d=0xFFFFFFFF, bo32=1, bo31=1, bo24=1, ovf=0
//  3 a=0x80000000,b=1 -> d=0x7FFFFFFF, bo32=0, bo31=1, ovf=1 (0 when FS32_OVF_EN undefined)
//  4 a=0x01000000,b=0,bi=1 -> d=0x00FFFFFF, bo24=1, bo31=0, bo32=0
//  5 start pulse with new operands mid-RUN -> ignored; first result unchanged; done pulses once
//  6 reset asserted in RUN step 2 -> busy=0, d=0, no done; then DW=1 run of case 2
//    -> done after 32 clk, same results

Source files
------------

// File: rtl/fs32_serial_if.sv
// rtl/fs32_serial_if.sv - request/operand/result bundle for fs32_serial
interface fs32_serial_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        bi;
  logic        busy;
  logic        done;
  logic [31:0] d;
  logic        bo32;
  logic        bo31;
  logic        bo24;
  logic        ovf;

  modport master (output start, a, b, bi,
                  input  busy, done, d, bo32, bo31, bo24, ovf);
  modport slave  (input  start, a, b, bi,
                  output busy, done, d, bo32, bo31, bo24, ovf);
endinterface

// File: rtl/fs32_serial.sv
// rtl/fs32_serial.sv - digit-serial 32-bit subtractor d = a - b - bi, LSB digit first
// Signed-overflow flag ovf is built only when FS32_OVF_EN is defined.
module fs32_serial #(
  parameter int DW = 8
) (
  input  logic          sys_clk,
  input  logic          reset,
  fs32_serial_if.slave  s
);
  localparam int NSTEP = 32 / DW;
  localparam int SW    = $clog2(NSTEP);
  localparam int S24   = 23 / DW;
  localparam int I24   = 23 % DW;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] step;
  logic [31:0]   ash, bsh, d_q;
  logic          borrow, bo32_q, bo31_q, bo24_q, done_q;
  logic [DW-1:0] dig;
  logic          bn, b31, b24;
  logic          last, accept;

  assign last   = (step == SW'(NSTEP - 1));
  assign accept = (state == IDLE) && s.start;

  always_ff @(posedge sys_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (s.start) state_nx = RUN;
      RUN:     if (last)    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s.busy = (state == RUN);
  end

  // Bitwise borrow ripple so bo31/bo24 come from exact bit positions inside a digit.
  always_comb begin
    logic br;
    br  = borrow;
    dig = '0;
    b31 = 1'b0;
    b24 = 1'b0;
    for (int i = 0; i < DW; i++) begin
      if (i == DW - 1) b31 = br;
      dig[i] = ash[i] ^ bsh[i] ^ br;
      br     = (~ash[i] & bsh[i]) | (~(ash[i] ^ bsh[i]) & br);
      if (i == I24) b24 = br;
    end
    bn = br;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      step   <= '0;
      ash    <= '0;
      bsh    <= '0;
      borrow <= 1'b0;
      d_q    <= '0;
      bo32_q <= 1'b0;
      bo31_q <= 1'b0;
      bo24_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        ash    <= s.a;
        bsh    <= s.b;
        borrow <= s.bi;
        step   <= '0;
      end else if (state == RUN) begin
        d_q[step*DW +: DW] <= dig;
        ash    <= ash >> DW;
        bsh    <= bsh >> DW;
        borrow <= bn;
        step   <= step + 1'b1;
        if (step == SW'(S24)) bo24_q <= b24;
        if (last) begin
          bo32_q <= bn;
          bo31_q <= b31;
          done_q <= 1'b1;
        end
      end
    end
  end

`ifdef FS32_OVF_EN
  logic ovf_q;
  always_ff @(posedge sys_clk) begin
    if (reset)                     ovf_q <= 1'b0;
    else if ((state == RUN) && last) ovf_q <= b31 ^ bn;
  end
  assign s.ovf = ovf_q;
`else
  assign s.ovf = 1'b0;
`endif

  assign s.done = done_q;
  assign s.d    = d_q;
  assign s.bo32 = bo32_q;
  assign s.bo31 = bo31_q;
  assign s.bo24 = bo24_q;
endmodule
